// File: rtl/arb3_rr_pkg.sv
// Shared definitions for the three-requester round-robin arbiter.
package arb3_rr_pkg;

  // Arbiter control state: no owner, or one requester holds the grant
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  // Width of the hold counter
  localparam int HCNT_W = 8;

  // Next index in the 0 -> 1 -> 2 -> 0 rotation (3 folds back to 0)
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/arb3_rr_pick.sv
// Combinational rotating-priority pick among three requesters.
// Each win term ANDs a requester's eligibility with the inverted
// eligibility of every requester ahead of it in the current rotation.
module arb3_rr_pick
  import arb3_rr_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic [2:0] excl,
  output logic [2:0] win,
  output logic [1:0] wid
);

  logic [2:0] elig;

  assign elig = req & ~excl;

  // Select the rotation that starts at ptr; ptr==3 behaves as 0
  always_comb begin
    win = 3'b000;
    case (ptr)
      2'd1: begin
        win[1] = elig[1];
        win[2] = elig[2] & ~elig[1];
        win[0] = elig[0] & ~elig[1] & ~elig[2];
      end
      2'd2: begin
        win[2] = elig[2];
        win[0] = elig[0] & ~elig[2];
        win[1] = elig[1] & ~elig[2] & ~elig[0];
      end
      default: begin
        win[0] = elig[0];
        win[1] = elig[1] & ~elig[0];
        win[2] = elig[2] & ~elig[0] & ~elig[1];
      end
    endcase
  end

  // Encode the one-hot winner as an index; 0 when nobody wins
  always_comb begin
    wid = 2'd0;
    if (win[1]) wid = 2'd1;
    if (win[2]) wid = 2'd2;
  end

endmodule

// File: rtl/arb3_rr.sv
// Three-requester round-robin arbiter with registered one-hot grant and
// a bounded hold time while other requesters are waiting.
module arb3_rr
  import arb3_rr_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int INIT_PTR = 0
) (
  input  logic       C,
  input  logic       R,
  input  logic       CE,
  input  logic [2:0] REQ,
  output logic [2:0] GNT,
  output logic [1:0] GID,
  output logic       BUSY
);

  localparam bit PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [HCNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HCNT_W'(MAX_HOLD - 1);
  localparam logic [1:0] PTR_RST =
    (INIT_PTR >= 1 && INIT_PTR <= 2) ? 2'(INIT_PTR) : 2'd0;

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [1:0]        gid_q, gid_d;

  logic [1:0]        pick_ptr;
  logic [2:0]        pick_excl;
  logic [2:0]        win;
  logic [1:0]        wid;
  logic              own_req;
  logic              others;

  assign own_req = |(REQ & gnt_q);
  assign others  = |(REQ & ~gnt_q);

  // While owning, both release and preemption re-pick from the owner's
  // successor with the owner masked, so one picker serves every case
  always_comb begin
    pick_ptr  = ptr_q;
    pick_excl = 3'b000;
    if (state_q == ST_OWN) begin
      pick_ptr  = ptr_inc(gid_q);
      pick_excl = gnt_q;
    end
  end

  arb3_rr_pick u_pick (
    .req  (REQ),
    .ptr  (pick_ptr),
    .excl (pick_excl),
    .win  (win),
    .wid  (wid)
  );

  // Next-state logic: everything holds unless CE is high
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    gnt_d   = gnt_q;
    gid_d   = gid_q;
    if (CE) begin
      case (state_q)
        ST_IDLE: begin
          if (|REQ) begin
            gnt_d   = win;
            gid_d   = wid;
            hcnt_d  = '0;
            state_d = ST_OWN;
          end
        end
        default: begin
          if (!own_req) begin
            // Release wins over a coincident preemption
            ptr_d  = ptr_inc(gid_q);
            hcnt_d = '0;
            if (|win) begin
              gnt_d = win;
              gid_d = wid;
            end else begin
              gnt_d   = 3'b000;
              gid_d   = 2'd0;
              state_d = ST_IDLE;
            end
          end else if (PREEMPT_EN && others && (hcnt_q == HOLD_LAST)) begin
            ptr_d  = ptr_inc(gid_q);
            gnt_d  = win;
            gid_d  = wid;
            hcnt_d = '0;
          end else if (PREEMPT_EN && others) begin
            hcnt_d = (hcnt_q == HOLD_LAST) ? hcnt_q : hcnt_q + HCNT_W'(1);
          end else begin
            // A lone owner never accumulates hold time
            hcnt_d = '0;
          end
        end
      endcase
    end
  end

  // State registers; reset overrides CE
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RST;
      hcnt_q  <= '0;
      gnt_q   <= 3'b000;
      gid_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      gnt_q   <= gnt_d;
      gid_q   <= gid_d;
    end
  end

  assign GNT  = gnt_q;
  assign GID  = gid_q;
  assign BUSY = |gnt_q;

endmodule

// File: tb/tb_arb3_rr.sv
// Bench for arb3_rr: directed steps plus randomized traffic, checked
// against a rule-level reference model for two parameterisations.
module tb_arb3_rr;

  logic       clk = 1'b0;
  logic       R;
  logic       CE;
  logic [2:0] REQ;

  logic [2:0] gnt4, gnt0;
  logic [1:0] gid4, gid0;
  logic       busy4, busy0;

  int tests = 0;
  int fails = 0;

  // Reference model state per instance: 0 = MAX_HOLD 4, 1 = MAX_HOLD 0
  int m_owner[2];
  int m_ptr[2];
  int m_cnt[2];
  int m_hold[2] = '{4, 0};
  int m_init[2] = '{0, 0};

  always #5 clk = ~clk;

  arb3_rr #(.MAX_HOLD(4), .INIT_PTR(0)) u_dut_h4 (
    .C(clk), .R(R), .CE(CE), .REQ(REQ), .GNT(gnt4), .GID(gid4), .BUSY(busy4)
  );

  arb3_rr #(.MAX_HOLD(0), .INIT_PTR(3)) u_dut_h0 (
    .C(clk), .R(R), .CE(CE), .REQ(REQ), .GNT(gnt0), .GID(gid0), .BUSY(busy0)
  );

  function automatic logic [5:0] enc(input int idx);
    if (idx < 0) return 6'b0;
    return {1'b1, 2'(idx), 3'(1 << idx)};
  endfunction

  function automatic int pick(input logic [2:0] req, input int start, input int excl);
    for (int j = 0; j < 3; j++) begin
      int i;
      i = (start + j) % 3;
      if (i != excl && req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input int n, input logic [2:0] req, input logic ce, input logic r);
    int k;
    if (r) begin
      m_owner[n] = -1;
      m_ptr[n]   = m_init[n];
      m_cnt[n]   = 0;
    end else if (ce) begin
      if (m_owner[n] < 0) begin
        m_owner[n] = pick(req, m_ptr[n], -1);
        m_cnt[n]   = 0;
      end else begin
        k = m_owner[n];
        if (!req[k]) begin
          m_ptr[n]   = (k + 1) % 3;
          m_owner[n] = pick(req, m_ptr[n], k);
          m_cnt[n]   = 0;
        end else if (m_hold[n] != 0 && m_cnt[n] == m_hold[n] - 1 && (req & ~3'(1 << k)) != 0) begin
          m_ptr[n]   = (k + 1) % 3;
          m_owner[n] = pick(req, m_ptr[n], k);
          m_cnt[n]   = 0;
        end else if (m_hold[n] != 0 && (req & ~3'(1 << k)) != 0) begin
          m_cnt[n] = (m_cnt[n] + 1 > m_hold[n] - 1) ? m_hold[n] - 1 : m_cnt[n] + 1;
        end else begin
          m_cnt[n] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed={busy,gid,gnt}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1 ns after the edge
  task automatic cyc(input logic [2:0] req, input logic ce, input logic r);
    REQ = req;
    CE  = ce;
    R   = r;
    @(posedge clk);
    model_step(0, req, ce, r);
    model_step(1, req, ce, r);
    #1;
    chk("model_h4", {busy4, gid4, gnt4}, enc(m_owner[0]));
    chk("model_h0", {busy0, gid0, gnt0}, enc(m_owner[1]));
  endtask

  initial begin
    R   = 1'b1;
    CE  = 1'b0;
    REQ = 3'b000;
    m_owner = '{-1, -1};
    m_ptr   = '{0, 0};
    m_cnt   = '{0, 0};

    // Reset with all requesting, CE ignored
    cyc(3'b111, 1'b0, 1'b1);
    cyc(3'b111, 1'b1, 1'b1);
    chk("reset_idle", {busy4, gid4, gnt4}, 6'b0_00_000);

    // First grant one edge after reset release
    cyc(3'b111, 1'b1, 1'b0);
    chk("first_grant", {busy4, gid4, gnt4}, 6'b1_00_001);

    // Rotation every 4 edges; MAX_HOLD=0 keeps requester 0 forever
    for (int e = 2; e <= 13; e++) begin
      cyc(3'b111, 1'b1, 1'b0);
      chk("rotation", {busy4, gid4, gnt4}, enc(((e - 1) / 4) % 3));
      chk("no_preempt", {busy0, gid0, gnt0}, 6'b1_00_001);
    end

    // Release handoff 1 -> 2, then release to idle
    cyc(3'b000, 1'b1, 1'b1);
    cyc(3'b010, 1'b1, 1'b0);
    chk("own1", {busy4, gid4, gnt4}, 6'b1_01_010);
    cyc(3'b110, 1'b1, 1'b0);
    chk("own1_hold", {busy4, gid4, gnt4}, 6'b1_01_010);
    cyc(3'b100, 1'b1, 1'b0);
    chk("handoff", {busy4, gid4, gnt4}, 6'b1_10_100);
    cyc(3'b000, 1'b1, 1'b0);
    chk("to_idle", {busy4, gid4, gnt4}, 6'b0_00_000);

    // Lone owner is never preempted; contender wins exactly 4 edges later
    cyc(3'b000, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      cyc(3'b001, 1'b1, 1'b0);
      chk("lone", {busy4, gid4, gnt4}, 6'b1_00_001);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc(3'b011, 1'b1, 1'b0);
      chk("contend", {busy4, gid4, gnt4}, (i < 4) ? 6'b1_00_001 : 6'b1_01_010);
    end

    // CE freeze with hold count at 2
    cyc(3'b000, 1'b1, 1'b1);
    cyc(3'b100, 1'b1, 1'b0);
    cyc(3'b101, 1'b1, 1'b0);
    cyc(3'b101, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(3'($urandom_range(0, 7)), 1'b0, 1'b0);
      chk("ce_freeze", {busy4, gid4, gnt4}, 6'b1_10_100);
    end
    cyc(3'b101, 1'b1, 1'b0);
    chk("ce_resume", {busy4, gid4, gnt4}, 6'b1_10_100);
    cyc(3'b101, 1'b1, 1'b0);
    chk("ce_preempt", {busy4, gid4, gnt4}, 6'b1_00_001);

    // Reset mid-grant coinciding with release: no handoff, pointer restored
    cyc(3'b000, 1'b1, 1'b1);
    cyc(3'b010, 1'b1, 1'b0);
    cyc(3'b100, 1'b1, 1'b1);
    chk("reset_mid", {busy4, gid4, gnt4}, 6'b0_00_000);
    cyc(3'b111, 1'b1, 1'b0);
    chk("ptr_init", {busy4, gid4, gnt4}, 6'b1_00_001);
    chk("ptr_init3", {busy0, gid0, gnt0}, 6'b1_00_001);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(3'($urandom_range(0, 7)), ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
